// File: rtl/cfc_sequencer.sv
// cfc_sequencer: drives one convolution filter core (up to 4 MAC lanes) through
// a full window evaluation: RESET, tap-major MUL stream, GET, then wait for done.
// Optional WAIT timeout is built when CFC_SEQ_TIMEOUT_EN is defined.

// Per-lane signed coefficient bank, one entry per tap.
module cfc_coef_lane #(
  parameter int NUM_TAPS = 9
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       we,
  input  logic [3:0] wr_tap,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_tap,
  output logic [7:0] rd_data
);
  logic [NUM_TAPS-1:0][7:0] coef;

  // write port; tap selects beyond the window match nothing and are dropped
  always_ff @(posedge clock) begin
    if (!reset_n) coef <= '0;
    else if (we)
      for (int t = 0; t < NUM_TAPS; t++)
        if (wr_tap == 4'(t)) coef[t] <= wr_data;
  end

  // read mux for the tap about to be issued
  always_comb begin
    rd_data = '0;
    for (int t = 0; t < NUM_TAPS; t++)
      if (rd_tap == 4'(t)) rd_data = coef[t];
  end
endmodule

module cfc_sequencer #(
  parameter int NUM_KERNELS = 4,
  parameter int NUM_TAPS    = 9,
  parameter int WAIT_LIMIT  = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [71:0] pixel_window,
  output logic        ready,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_kernel,
  input  logic [3:0]  cfg_tap,
  input  logic [7:0]  cfg_data,
  output logic [1:0]  op_code,
  output logic [1:0]  index,
  output logic [7:0]  value_a,
  output logic [7:0]  value_b,
  input  logic [31:0] cfc_data,
  input  logic        cfc_done,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        timeout_err
);
  if (NUM_KERNELS < 1 || NUM_KERNELS > 4 || NUM_TAPS < 1 || NUM_TAPS > 9 ||
      WAIT_LIMIT < 1) begin : g_param_chk
    $error("cfc_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MUL, S_GET, S_WAIT} state_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_RESET = 2'd1;
  localparam logic [1:0] OP_MUL   = 2'd2;
  localparam logic [1:0] OP_GET   = 2'd3;
  localparam logic [1:0] LAST_LANE = 2'(NUM_KERNELS - 1);
  localparam logic [3:0] LAST_TAP  = 4'(NUM_TAPS - 1);

  state_t      state, state_nx;
  logic [1:0]  lane, lane_nx;
  logic [3:0]  tap, tap_nx;
  logic        mul_last;
  logic [71:0] win;
  logic [7:0]  pix_sel, coef_sel;
  logic [1:0]  op_nx, idx_nx;
  logic [7:0]  va_nx, vb_nx;
  logic        res_ld;
  logic [NUM_KERNELS-1:0][7:0] lane_coef;

  for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_lane
    cfc_coef_lane #(.NUM_TAPS(NUM_TAPS)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (cfg_we && state == S_IDLE && cfg_kernel == 2'(k)),
      .wr_tap  (cfg_tap),
      .wr_data (cfg_data),
      .rd_tap  (tap_nx),
      .rd_data (lane_coef[k])
    );
  end

  assign mul_last = (state == S_MUL) && (lane == LAST_LANE) && (tap == LAST_TAP);

  // step walker: lanes innermost, taps outer; parked at 0 outside MUL
  always_comb begin
    lane_nx = '0;
    tap_nx  = '0;
    if (state == S_MUL) begin
      if (lane == LAST_LANE) tap_nx = tap + 4'd1;
      else begin
        lane_nx = lane + 2'd1;
        tap_nx  = tap;
      end
    end
  end

  // operand selection for the step about to be issued
  always_comb begin
    pix_sel  = '0;
    coef_sel = '0;
    for (int t = 0; t < NUM_TAPS; t++)
      if (tap_nx == 4'(t)) pix_sel = win[8*t +: 8];
    for (int k = 0; k < NUM_KERNELS; k++)
      if (lane_nx == 2'(k)) coef_sel = lane_coef[k];
  end

`ifdef CFC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  logic [CW-1:0] wait_cnt;
  logic          tmo_nx;

  // WAIT cycle counter; held at zero elsewhere so it is clear on WAIT entry
  always_ff @(posedge clock) begin
    if (!reset_n || state != S_WAIT) wait_cnt <= '0;
    else                             wait_cnt <= wait_cnt + CNT_ONE;
  end

  // one-cycle timeout pulse
  always_ff @(posedge clock) begin
    if (!reset_n) timeout_err <= 1'b0;
    else          timeout_err <= tmo_nx;
  end
`else
  assign timeout_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // next state and next registered outputs
  always_comb begin
    state_nx = state;
    op_nx    = OP_NOP;
    idx_nx   = '0;
    va_nx    = '0;
    vb_nx    = '0;
    res_ld   = 1'b0;
`ifdef CFC_SEQ_TIMEOUT_EN
    tmo_nx   = 1'b0;
`endif
    case (state)
      S_IDLE:
        if (start) begin
          state_nx = S_CLEAR;
          op_nx    = OP_RESET;
        end
      S_CLEAR, S_MUL:
        if (mul_last) begin
          state_nx = S_GET;
          op_nx    = OP_GET;
        end else begin
          state_nx = S_MUL;
          op_nx    = OP_MUL;
          idx_nx   = lane_nx;
          va_nx    = pix_sel;
          vb_nx    = coef_sel;
        end
      S_GET: state_nx = S_WAIT;
      S_WAIT:
        if (cfc_done) begin
          state_nx = S_IDLE;
          res_ld   = 1'b1;
        end
`ifdef CFC_SEQ_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          state_nx = S_IDLE;
          tmo_nx   = 1'b1;
        end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // registered outputs, step position and latched window
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lane         <= '0;
      tap          <= '0;
      op_code      <= OP_NOP;
      index        <= '0;
      value_a      <= '0;
      value_b      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      ready        <= 1'b1;
      win          <= '0;
    end else begin
      lane         <= lane_nx;
      tap          <= tap_nx;
      op_code      <= op_nx;
      index        <= idx_nx;
      value_a      <= va_nx;
      value_b      <= vb_nx;
      result_valid <= res_ld;
      ready        <= (state_nx == S_IDLE);
      if (res_ld) result <= cfc_data;
      if (state == S_IDLE && start) win <= pixel_window;
    end
  end
endmodule
